// File: rtl/river_scroller.sv
// river_scroller: vertically scrolling river renderer with green banks, fed by an external offset table.
// Optional moving foam stripes on the water when RIVER_WAVES_EN is defined.
module river_scroller #(
  parameter int STREAM_CENTER = 250,
  parameter int STREAM_OSC    = 30,
  parameter int STREAM_WIDTH  = 63,
  parameter int BANK_WIDTH    = 8,
  parameter int DEPTH_LOG2    = 8,
  parameter int OFFSET_W      = 6,
  parameter int SPEED_W       = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [9:0]            pixel_x,
  input  logic [9:0]            pixel_y,
  input  logic                  video_on,
  input  logic                  frame_tick,
  input  logic [SPEED_W-1:0]    speed,
  input  logic                  pause,
  output logic [DEPTH_LOG2-1:0] rom_addr,
  input  logic [OFFSET_W-1:0]   rom_data,
  output logic [DEPTH_LOG2-1:0] scroll_pos,
  output logic [2:0]            rgb
);
  localparam logic [2:0] NEGRO = 3'b000;
  localparam logic [2:0] AZUL  = 3'b001;
  localparam logic [2:0] VERDE = 3'b010;
  localparam logic [2:0] CYAN  = 3'b011;
  logic [SPEED_W-1:0]    speed_q, speed_d;
  logic [DEPTH_LOG2-1:0] scroll_q, scroll_d;
  logic [DEPTH_LOG2-1:0] rom_addr_q, rom_addr_d;
  logic [9:0]            x_q;
  logic                  von_q;
  logic [2:0]            rgb_q, rgb_d;
  logic signed [10:0]    left, right, bank_l, bank_r, xs;
  logic                  water, bank, foam;
  // Full-width subtract keeps every pixel_y bit in use; low bits equal the modular difference.
  always_comb begin
    speed_d    = frame_tick ? speed : speed_q;
    scroll_d   = (frame_tick && !pause) ? scroll_q + DEPTH_LOG2'(speed_q) : scroll_q;
    rom_addr_d = DEPTH_LOG2'(pixel_y - 10'(scroll_q));
  end
  always_comb begin
    left   = 11'(STREAM_CENTER - STREAM_OSC) + 11'(rom_data);
    right  = left + 11'(STREAM_WIDTH);
    bank_l = left - 11'(BANK_WIDTH);
    bank_r = right + 11'(BANK_WIDTH);
    xs     = {1'b0, x_q};
    water  = xs >= left && xs <= right;
    bank   = (xs >= bank_l && xs < left) || (xs > right && xs <= bank_r);
    rgb_d  = !von_q ? NEGRO : water ? (foam ? CYAN : AZUL) : bank ? VERDE : NEGRO;
  end
`ifdef RIVER_WAVES_EN
  logic [1:0] phase_q, phase_d;
  logic [3:0] y_q;
  always_comb begin
    phase_d = (frame_tick && !pause) ? phase_q + 2'd1 : phase_q;
    foam    = (y_q + {phase_q, 2'b00}) < 4'd2;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      phase_q <= '0;
      y_q     <= '0;
    end else begin
      phase_q <= phase_d;
      y_q     <= pixel_y[3:0];
    end
`else
  assign foam = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      speed_q    <= '0;
      scroll_q   <= '0;
      rom_addr_q <= '0;
      x_q        <= '0;
      von_q      <= 1'b0;
      rgb_q      <= NEGRO;
    end else begin
      speed_q    <= speed_d;
      scroll_q   <= scroll_d;
      rom_addr_q <= rom_addr_d;
      x_q        <= pixel_x;
      von_q      <= video_on;
      rgb_q      <= rgb_d;
    end
  assign rom_addr   = rom_addr_q;
  assign scroll_pos = scroll_q;
  assign rgb        = rgb_q;
endmodule

// File: tb/tb_river_scroller.sv
// tb_river_scroller: scoreboard bench for river_scroller; pixel colours are queued on drive and checked two clocks later.
module tb_river_scroller;
  localparam logic [2:0] NEGRO = 3'b000;
  localparam logic [2:0] AZUL  = 3'b001;
  localparam logic [2:0] VERDE = 3'b010;
  localparam logic [2:0] CYAN  = 3'b011;
`ifdef RIVER_WAVES_EN
  localparam logic [2:0] FOAM = CYAN;
`else
  localparam logic [2:0] FOAM = AZUL;
`endif
  logic       clk = 0;
  logic       reset = 1;
  logic [9:0] pixel_x = 0;
  logic [9:0] pixel_y = 0;
  logic       video_on = 0;
  logic       frame_tick = 0;
  logic [3:0] speed = 0;
  logic       pause = 0;
  logic [7:0] rom_addr;
  logic [5:0] rom_data = 0;
  logic [7:0] scroll_pos;
  logic [2:0] rgb;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  typedef struct {logic [2:0] exp; int due; int x; int y;} sb_t;
  sb_t q[$];

  river_scroller dut (
    .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .frame_tick(frame_tick), .speed(speed), .pause(pause), .rom_addr(rom_addr),
    .rom_data(rom_data), .scroll_pos(scroll_pos), .rgb(rgb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (q.size() > 0 && q[0].due <= cyc) begin
      total++;
      if (rgb !== q[0].exp) begin
        bad++;
        $display("FAIL pixel x=%0d y=%0d: rgb=%b expected=%b", q[0].x, q[0].y, rgb, q[0].exp);
      end
      void'(q.pop_front());
    end

  function automatic logic [2:0] exp_rgb(input int x, input int y, input bit von, input int rd);
    int l = 220 + rd;
    int r = l + 63;
    if (!von) return NEGRO;
    if (x >= l && x <= r) return ((y % 16) < 2) ? FOAM : AZUL;
    if ((x >= l - 8 && x < l) || (x > r && x <= r + 8)) return VERDE;
    return NEGRO;
  endfunction

  task automatic pix(input int x, input int y, input bit von, input logic [2:0] exp);
    sb_t e;
    @(negedge clk);
    pixel_x = 10'(x);
    pixel_y = 10'(y);
    video_on = von;
    e.exp = exp; e.due = cyc + 2; e.x = x; e.y = y;
    q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 6 && q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d pixels still pending, expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic tick(input int spd, input bit pse);
    @(negedge clk);
    speed = 4'(spd);
    pause = pse;
    frame_tick = 1;
    @(negedge clk);
    frame_tick = 0;
    pause = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    frame_tick = 0;
    video_on = 0;
    speed = 0;
    pause = 0;
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    rom_data = 0;
    pixel_x = 250;
    pixel_y = 5;
    video_on = 1;
    repeat (3) @(negedge clk);
    total++;
    if (rgb !== AZUL) begin bad++; $display("FAIL pre_reset_rgb: rgb=%b expected=%b", rgb, AZUL); end
    @(posedge clk);
    #2 reset = 1;
    #1;
    total++;
    if (rgb !== NEGRO) begin bad++; $display("FAIL async_reset_rgb: rgb=%b expected=%b", rgb, NEGRO); end
    total++;
    if (rom_addr !== 8'd0) begin bad++; $display("FAIL async_reset_addr: rom_addr=%0d expected=0", rom_addr); end
    total++;
    if (scroll_pos !== 8'd0) begin bad++; $display("FAIL async_reset_scroll: scroll_pos=%0d expected=0", scroll_pos); end
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    total++;
    if (rgb !== NEGRO) begin bad++; $display("FAIL release_cycle1: rgb=%b expected=%b", rgb, NEGRO); end
    @(negedge clk);
    total++;
    if (rgb !== AZUL) begin bad++; $display("FAIL release_cycle2: rgb=%b expected=%b", rgb, AZUL); end
  endtask

  task automatic test_geometry();
    rom_data = 0;
    @(negedge clk);
    pixel_y = 5;
    @(negedge clk);
    total++;
    if (rom_addr !== 8'd5) begin bad++; $display("FAIL geom_addr: rom_addr=%0d expected=5", rom_addr); end
    pix(220, 5, 1, AZUL);
    pix(283, 5, 1, AZUL);
    pix(284, 5, 1, VERDE);
    pix(212, 5, 1, VERDE);
    pix(211, 5, 1, NEGRO);
    pix(292, 5, 1, NEGRO);
    pix(291, 5, 1, VERDE);
    pix(250, 5, 0, NEGRO);
    drain();
  endtask

  task automatic test_max_entry();
    rom_data = 63;
    pix(346, 5, 1, AZUL);
    pix(283, 5, 1, AZUL);
    pix(282, 5, 1, VERDE);
    pix(354, 5, 1, VERDE);
    pix(355, 5, 1, NEGRO);
    pix(347, 5, 1, VERDE);
    drain();
  endtask

  task automatic test_scroll();
    tick(3, 0);
    total++;
    if (scroll_pos !== 8'd0) begin bad++; $display("FAIL tick1: scroll_pos=%0d expected=0", scroll_pos); end
    tick(3, 0);
    total++;
    if (scroll_pos !== 8'd3) begin bad++; $display("FAIL tick2: scroll_pos=%0d expected=3", scroll_pos); end
    speed = 9;
    repeat (3) @(negedge clk);
    tick(3, 0);
    total++;
    if (scroll_pos !== 8'd6) begin bad++; $display("FAIL tick3: scroll_pos=%0d expected=6", scroll_pos); end
    pixel_y = 2;
    @(negedge clk);
    total++;
    if (rom_addr !== 8'd252) begin bad++; $display("FAIL addr_wrap: rom_addr=%0d expected=252", rom_addr); end
  endtask

  task automatic test_wrap_pause();
    do_reset();
    tick(15, 0);
    repeat (15) tick(15, 0);
    tick(14, 0);
    total++;
    if (scroll_pos !== 8'd240) begin bad++; $display("FAIL ramp: scroll_pos=%0d expected=240", scroll_pos); end
    tick(5, 0);
    total++;
    if (scroll_pos !== 8'd254) begin bad++; $display("FAIL pre_wrap: scroll_pos=%0d expected=254", scroll_pos); end
    tick(9, 0);
    total++;
    if (scroll_pos !== 8'd3) begin bad++; $display("FAIL wrap: scroll_pos=%0d expected=3", scroll_pos); end
    tick(2, 1);
    total++;
    if (scroll_pos !== 8'd3) begin bad++; $display("FAIL pause_hold: scroll_pos=%0d expected=3", scroll_pos); end
    tick(0, 0);
    total++;
    if (scroll_pos !== 8'd5) begin bad++; $display("FAIL pause_latch: scroll_pos=%0d expected=5", scroll_pos); end
  endtask

  task automatic test_waves();
    do_reset();
    rom_data = 0;
    pix(250, 0, 1, FOAM);
    pix(250, 1, 1, FOAM);
    pix(250, 2, 1, AZUL);
    pix(214, 0, 1, VERDE);
    drain();
    tick(0, 0);
    pix(250, 12, 1, FOAM);
    pix(250, 14, 1, AZUL);
    pix(250, 0, 1, AZUL);
    drain();
  endtask

  task automatic test_back_to_back();
    do_reset();
    rom_data = 17;
    for (int i = 0; i < 40; i++) begin
      int x = $urandom_range(360, 200);
      int y = $urandom_range(1023, 0);
      bit von = ($urandom_range(3, 0) != 0);
      pix(x, y, von, exp_rgb(x, y, von, 17));
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_geometry();
    test_max_entry();
    test_scroll();
    test_wrap_pause();
    test_waves();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
